// File: rtl/rf_arb_pkg.sv
// Shared constants, staged-write record and register-file port mapping for regfile_write_arbiter.
package rf_arb_pkg;

    localparam int L = 16;
    localparam int A = 3;
    localparam int R = 1 << A;

    localparam logic [A-1:0] FLAGS_ADDR = A'(R - 1);
    localparam logic [A-1:0] ZERO_ADDR  = {A{1'b0}};

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    typedef struct packed {
        logic [A-1:0] addr;
        logic [L-1:0] data;
        logic [L-1:0] flags;
        logic         flags_valid;
        logic         src;
    } staged_wr_t;

    typedef struct packed {
        logic [A-1:0] addr;
        logic [L-1:0] data;
        logic [L-1:0] new_flags;
    } rf_port_t;

    // The register file writes AddrA and flags every edge, so an empty stage maps to r0 <- 0, flags <- flags.
    function automatic rf_port_t map_write(input logic valid, input staged_wr_t wr,
                                           input logic [L-1:0] cur_flags);
        rf_port_t p;
        p.addr      = ZERO_ADDR;
        p.data      = {L{1'b0}};
        p.new_flags = cur_flags;
        if (valid) begin
            case (wr.addr)
                ZERO_ADDR: begin
                    p.new_flags = wr.flags_valid ? wr.flags : cur_flags;
                end
                FLAGS_ADDR: begin
                    p.addr      = FLAGS_ADDR;
                    p.data      = wr.data;
                    p.new_flags = wr.flags_valid ? wr.flags : wr.data;
                end
                default: begin
                    p.addr      = wr.addr;
                    p.data      = wr.data;
                    p.new_flags = wr.flags_valid ? wr.flags : cur_flags;
                end
            endcase
        end else begin
            p.new_flags = cur_flags;
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the priority pointer names the requester that wins a conflict.
module rr_arbiter2
    import rf_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and pointer advance to the requester that did not win.
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_q == REQ_ALU) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            ptr_d = REQ_MEM;
        end else if (gnt_o[1]) begin
            ptr_d = REQ_ALU;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= REQ_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU/MEM writeback onto the register file write port through a one-cycle stage.
// Optional macro RF_ARB_FORWARD_EN adds read-port bypass of the staged write.
module regfile_write_arbiter
    import rf_arb_pkg::*;
(
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         AluValid,
    output logic         AluReady,
    input  logic [A-1:0] AluAddr,
    input  logic [L-1:0] AluData,
    input  logic         AluFlagsValid,
    input  logic [L-1:0] AluFlags,
    input  logic         MemValid,
    output logic         MemReady,
    input  logic [A-1:0] MemAddr,
    input  logic [L-1:0] MemData,
    input  logic         MemFlagsValid,
    input  logic [L-1:0] MemFlags,
    input  logic [L-1:0] RfFlags,
    output logic [A-1:0] RfAddrA,
    output logic [L-1:0] RfDataA,
    output logic [L-1:0] RfNewFlags,
    output logic         Commit,
`ifdef RF_ARB_FORWARD_EN
    input  logic [A-1:0] RdAddrB,
    input  logic [A-1:0] RdAddrC,
    input  logic [L-1:0] RfRdDataB,
    input  logic [L-1:0] RfRdDataC,
    output logic [L-1:0] FwdDataB,
    output logic [L-1:0] FwdDataC,
`endif
    output logic         CommitSrc
);

    logic [1:0] gnt_s;
    logic       stage_valid_q;
    logic       stage_valid_d;
    staged_wr_t stage_q;
    staged_wr_t stage_d;
    rf_port_t   port_s;

    rr_arbiter2 u_arb (
        .clk_i  (Clk),
        .rst_ni (ResetN),
        .req_i  ({MemValid, AluValid}),
        .gnt_o  (gnt_s)
    );

    assign AluReady = gnt_s[0];
    assign MemReady = gnt_s[1];

    // Select the granted payload for capture into the stage.
    always_comb begin
        stage_valid_d = gnt_s[0] | gnt_s[1];
        if (gnt_s[1]) begin
            stage_d = '{addr: MemAddr, data: MemData, flags: MemFlags,
                        flags_valid: MemFlagsValid, src: REQ_MEM};
        end else begin
            stage_d = '{addr: AluAddr, data: AluData, flags: AluFlags,
                        flags_valid: AluFlagsValid, src: REQ_ALU};
        end
    end

    // Stage register; it drains every cycle, so no hold path is needed.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            stage_valid_q <= 1'b0;
            stage_q       <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_q       <= stage_d;
        end
    end

    assign port_s     = map_write(stage_valid_q, stage_q, RfFlags);
    assign RfAddrA    = port_s.addr;
    assign RfDataA    = port_s.data;
    assign RfNewFlags = port_s.new_flags;
    assign Commit     = stage_valid_q;
    assign CommitSrc  = stage_valid_q & stage_q.src;

`ifdef RF_ARB_FORWARD_EN
    // Bypass: flags reads see the effective new flags; r0 is never forwarded.
    always_comb begin
        FwdDataB = RfRdDataB;
        FwdDataC = RfRdDataC;
        if (stage_valid_q && (RdAddrB == FLAGS_ADDR)) begin
            FwdDataB = port_s.new_flags;
        end else if (stage_valid_q && (RdAddrB != ZERO_ADDR) && (RdAddrB == stage_q.addr)) begin
            FwdDataB = port_s.data;
        end else begin
            FwdDataB = RfRdDataB;
        end
        if (stage_valid_q && (RdAddrC == FLAGS_ADDR)) begin
            FwdDataC = port_s.new_flags;
        end else if (stage_valid_q && (RdAddrC != ZERO_ADDR) && (RdAddrC == stage_q.addr)) begin
            FwdDataC = port_s.data;
        end else begin
            FwdDataC = RfRdDataC;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter with a behavioural 8 x 16 register file.
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        AluValid, AluReady, AluFlagsValid;
    logic [2:0]  AluAddr;
    logic [15:0] AluData, AluFlags;
    logic        MemValid, MemReady, MemFlagsValid;
    logic [2:0]  MemAddr;
    logic [15:0] MemData, MemFlags;
    logic [15:0] RfFlags;
    logic [2:0]  RfAddrA;
    logic [15:0] RfDataA, RfNewFlags;
    logic        Commit, CommitSrc;
`ifdef RF_ARB_FORWARD_EN
    logic [2:0]  RdAddrB, RdAddrC;
    logic [15:0] RfRdDataB, RfRdDataC, FwdDataB, FwdDataC;
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0] rf [0:7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0005};

    always #5 Clk = ~Clk;

    regfile_write_arbiter dut (
        .Clk(Clk), .ResetN(ResetN),
        .AluValid(AluValid), .AluReady(AluReady), .AluAddr(AluAddr), .AluData(AluData),
        .AluFlagsValid(AluFlagsValid), .AluFlags(AluFlags),
        .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr), .MemData(MemData),
        .MemFlagsValid(MemFlagsValid), .MemFlags(MemFlags),
        .RfFlags(RfFlags), .RfAddrA(RfAddrA), .RfDataA(RfDataA), .RfNewFlags(RfNewFlags),
        .Commit(Commit),
`ifdef RF_ARB_FORWARD_EN
        .RdAddrB(RdAddrB), .RdAddrC(RdAddrC), .RfRdDataB(RfRdDataB), .RfRdDataC(RfRdDataC),
        .FwdDataB(FwdDataB), .FwdDataC(FwdDataC),
`endif
        .CommitSrc(CommitSrc)
    );

    // Register file: both ports written every edge, flags write wins on address 7, r0 hardwired.
    always @(posedge Clk) begin
        if (RfAddrA != 3'd0) rf[RfAddrA] <= RfDataA;
        rf[7] <= RfNewFlags;
    end

    assign RfFlags = rf[7];
`ifdef RF_ARB_FORWARD_EN
    assign RfRdDataB = rf[RdAddrB];
    assign RfRdDataC = rf[RdAddrC];
`endif

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        ResetN = 1'b0;
        AluValid = 1'b0; AluAddr = 3'd0; AluData = 16'h0; AluFlagsValid = 1'b0; AluFlags = 16'h0;
        MemValid = 1'b0; MemAddr = 3'd0; MemData = 16'h0; MemFlagsValid = 1'b0; MemFlags = 16'h0;
`ifdef RF_ARB_FORWARD_EN
        RdAddrB = 3'd0; RdAddrC = 3'd0;
`endif
        #12 ResetN = 1'b1;
        tick();

        // 1. idle pattern after reset
        check("idle_commit", {15'd0, Commit}, 16'd1 - 16'd1);
        check("idle_addr", {13'd0, RfAddrA}, 16'h0000);
        check("idle_data", RfDataA, 16'h0000);
        check("idle_flags", RfNewFlags, 16'h0005);
        check("idle_src", {15'd0, CommitSrc}, 16'h0000);
        tick();
        check("idle_rf7", rf[7], 16'h0005);

        // 2. single ALU write to r3
        AluValid = 1'b1; AluAddr = 3'd3; AluData = 16'h1234;
        #1;
        check("alu_ready", {15'd0, AluReady}, 16'h0001);
        check("mem_ready_idle", {15'd0, MemReady}, 16'h0000);
        tick();
        AluValid = 1'b0;
        #1;
        check("alu_commit", {15'd0, Commit}, 16'h0001);
        check("alu_addr", {13'd0, RfAddrA}, 16'h0003);
        check("alu_data", RfDataA, 16'h1234);
        check("alu_src", {15'd0, CommitSrc}, 16'h0000);
        tick();
        check("alu_r3", rf[3], 16'h1234);
        check("alu_drained", {15'd0, Commit}, 16'h0000);

        // MEM-only write to r4 moves the pointer back to ALU
        MemValid = 1'b1; MemAddr = 3'd4; MemData = 16'h0044;
        #1;
        check("mem_ready", {15'd0, MemReady}, 16'h0001);
        tick();
        MemValid = 1'b0;
        check("mem_src", {15'd0, CommitSrc}, 16'h0001);
        tick();
        check("mem_r4", rf[4], 16'h0044);

        // 3. conflict for 4 cycles: ALU, MEM, ALU, MEM
        AluValid = 1'b1; AluAddr = 3'd1; AluData = 16'h0011;
        MemValid = 1'b1; MemAddr = 3'd2; MemData = 16'h0022;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_alu_ready", {15'd0, AluReady}, (i % 2 == 0) ? 16'h0001 : 16'h0000);
            check("rr_mem_ready", {15'd0, MemReady}, (i % 2 == 0) ? 16'h0000 : 16'h0001);
            tick();
            if (i == 3) begin
                AluValid = 1'b0; MemValid = 1'b0;
            end
            check("rr_commit", {15'd0, Commit}, 16'h0001);
            check("rr_src", {15'd0, CommitSrc}, (i % 2 == 0) ? 16'h0000 : 16'h0001);
        end
        tick();
        check("rr_r1", rf[1], 16'h0011);
        check("rr_r2", rf[2], 16'h0022);

        // 4. flags register writes from MEM
        MemValid = 1'b1; MemAddr = 3'd7; MemData = 16'hAAAA; MemFlagsValid = 1'b1; MemFlags = 16'h0001;
        tick();
        MemValid = 1'b0;
        check("fl_addr", {13'd0, RfAddrA}, 16'h0007);
        check("fl_newflags", RfNewFlags, 16'h0001);
        tick();
        check("fl_rf7", rf[7], 16'h0001);
        MemValid = 1'b1; MemFlagsValid = 1'b0;
        tick();
        MemValid = 1'b0;
        check("fl_data_newflags", RfNewFlags, 16'hAAAA);
        tick();
        check("fl_data_rf7", rf[7], 16'hAAAA);

        // 5. r0 target: data dropped, flags-only write
        AluValid = 1'b1; AluAddr = 3'd0; AluData = 16'hFFFF; AluFlagsValid = 1'b1; AluFlags = 16'h0008;
        tick();
        AluValid = 1'b0; AluFlagsValid = 1'b0;
        check("z_data", RfDataA, 16'h0000);
        check("z_addr", {13'd0, RfAddrA}, 16'h0000);
        check("z_newflags", RfNewFlags, 16'h0008);
        tick();
        check("z_r0", rf[0], 16'h0000);
        check("z_rf7", rf[7], 16'h0008);

        // 6. reset during a staged write to r5
        AluValid = 1'b1; AluAddr = 3'd5; AluData = 16'h00BE;
        tick();
        AluValid = 1'b0;
        check("rst_pre_commit", {15'd0, Commit}, 16'h0001);
`ifdef RF_ARB_FORWARD_EN
        RdAddrB = 3'd5; RdAddrC = 3'd3;
        #1;
        check("fwd_b", FwdDataB, 16'h00BE);
        check("fwd_c_passthru", FwdDataC, 16'h1234);
        RdAddrC = 3'd7;
        #1;
        check("fwd_c_flags", FwdDataC, 16'h0008);
`endif
        ResetN = 1'b0;
        #1;
        check("rst_commit", {15'd0, Commit}, 16'h0000);
        check("rst_addr", {13'd0, RfAddrA}, 16'h0000);
        check("rst_newflags", RfNewFlags, 16'h0008);
        tick();
        check("rst_r5", rf[5], 16'h0000);
        ResetN = 1'b1;
        tick();
        check("rst_after", {15'd0, Commit}, 16'h0000);
        check("rst_rf7", rf[7], 16'h0008);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (AddrA/InDataA) and the flags-write input of the 16-bit, 8-entry RegisterFile.
- Shares that port between two writeback requesters, ALU and MEM, using a 2-way round-robin scheme.
- Registers the granted write for one cycle, then drives it onto the register file.
- When no write is pending, drives a harmless idle pattern: r0 ← 0, flags ← current flags. The register file writes both every clock, so this is required.

Parameters:
- L, 16, data/register width
- A, 3, register address width; register count R = 2^A
- FLAGS_ADDR, R-1 (7), address of the flags register
- ZERO_ADDR, 0, hardwired-zero register

Ports:
- Clk  in  1  system clock, rising edge
- ResetN  in  1  asynchronous, active-low reset
- AluValid  in  1  ALU write request
- AluReady  out  1  ALU request accepted this cycle
- AluAddr  in  A  ALU destination register
- AluData  in  L  ALU write data
- AluFlagsValid  in  1  ALU also updates flags
- AluFlags  in  L  ALU new flags
- MemValid, MemReady, MemAddr, MemData, MemFlagsValid, MemFlags  —  same as Alu*, for the MEM requester
- RfFlags  in  L  current flags (from register file OutFlags)
- RfAddrA  out  A  to register file AddrA
- RfDataA  out  L  to register file InDataA
- RfNewFlags  out  L  to register file InNewFlags
- Commit  out  1  staged write is being applied at the next edge
- CommitSrc  out  1  requester owning the staged write (0 = ALU, 1 = MEM)

Behaviour:
Reset:
- Staged valid = 0.
- Priority pointer = ALU.
- RfAddrA = 0, RfDataA = 0, RfNewFlags = RfFlags, Commit = 0, CommitSrc = 0.
- Reset may assert mid-transfer: the staged write is discarded and the register file receives only the idle pattern.

Handshake:
- A transfer occurs when Valid and Ready are both high on a rising edge.
- Ready is combinational; it is high only for the requester granted this cycle, and never high while that requester's Valid is low.
- Requesters hold payload stable until Ready.

Arbitration:
- One valid requester: it is granted.
- Both valid: the requester named by the priority pointer is granted.
- After any grant, the pointer moves to the non-granted requester.
- No grant: the pointer holds.
- The stage drains every cycle, so back-pressure exists only through the loser of a conflict.
- Same Addr from both requesters: arbitrate normally. The loser commits the following cycle, so the later write wins. Ordering is the requesters' responsibility.

Stage timing:
- The accepted request is captured at edge N.
- In cycle N+1: Commit = 1, and the Rf* outputs carry the write.
- The register file updates at edge N+1.
- Latency from acceptance to architectural visibility: 1 cycle.
- Throughput: 1 write per cycle.

Output mapping while staged valid:
- Addr = ZERO_ADDR: RfAddrA = 0, RfDataA = 0 (data is dropped). If FlagsValid, RfNewFlags = Flags (a flags-only write); otherwise RfNewFlags = RfFlags.
- Addr = FLAGS_ADDR: RfAddrA = 7. RfNewFlags = Flags if FlagsValid, else Data. The flags payload takes precedence over Data, matching the register file's same-edge overwrite.
- Any other Addr: RfAddrA = Addr, RfDataA = Data. RfNewFlags = Flags if FlagsValid, else RfFlags.

Idle (staged valid = 0): RfAddrA = 0, RfDataA = 0, RfNewFlags = RfFlags, Commit = 0.

Optional Feature:
Macro: RF_ARB_FORWARD_EN

When defined:
- Adds ports RdAddrB, RdAddrC (in, A), RfRdDataB, RfRdDataC (in, L), FwdDataB, FwdDataC (out, L).
- FwdDataX = the staged effective value when Commit is high and the staged write targets RdAddrX.
- A flags-register read returns the effective RfNewFlags.
- Address 0 is never forwarded.
- Otherwise FwdDataX = RfRdDataX.
- Purely combinational.

When undefined: these ports and that logic are absent; consumers read the register file directly and see the write one cycle later.

Decomposition:
- Package rf_arb_pkg: L, A, FLAGS_ADDR, ZERO_ADDR, requester index constants (REQ_ALU = 0, REQ_MEM = 1), and the staged-write struct {addr, data, flags, flags_valid, src}.
- Sub-module rr_arbiter2: 2-way round-robin grant with its priority flop, ResetN-reset to ALU.

Test Plan:
1. Reset, then idle cycles → RfAddrA = 0, RfDataA = 0, RfNewFlags tracks RfFlags = 0x0005, Commit = 0.
2. AluValid, AluAddr = 3, AluData = 0x1234 → AluReady same cycle; next cycle Commit = 1, RfAddrA = 3, RfDataA = 0x1234; r3 = 0x1234 after that edge.
3. Both valid for 4 cycles (ALU→r1 0x0011, MEM→r2 0x0022, payloads held) → grants alternate ALU, MEM, ALU, MEM. CommitSrc sequence 0, 1, 0, 1, each one cycle after its grant.
4. MemAddr = 7, MemData = 0xAAAA, MemFlagsValid = 1, MemFlags = 0x0001 → RfNewFlags = 0x0001; flags register = 0x0001 after the edge. Repeat with MemFlagsValid = 0 → flags register = 0xAAAA.
5. AluAddr = 0, AluData = 0xFFFF, AluFlagsValid = 1, AluFlags = 0x0008 → RfDataA = 0, r0 stays 0, flags = 0x0008.
6. ResetN low during a staged write → Commit = 0 immediately and target register unchanged. With RF_ARB_FORWARD_EN, a staged r5 = 0x00BE and RdAddrB = 5 → FwdDataB = 0x00BE.
